// File: rtl/conv_encoder_r4.sv
// conv_encoder_r4 : radix-4 (2 bits/cycle) rate-1/2 convolutional encoder.
//   Encodes one frame of FRAME_LEN data bits and then appends K-1 zero tail
//   bits, so the decoder's traceback always starts from state 0.
//
// Ports
//   clk, rst      clock; asynchronous active-low reset
//   en            global enable; 0 freezes every register and forces o_ready=0
//   i_start       frame start pulse, only looked at in IDLE
//   i_data[1:0]   data beat, [1] is earlier in time; i_valid qualifies it
//   o_ready       encoder takes i_data this cycle
//   i_ready       downstream takes o_code this cycle
//   o_code[3:0]   {c0,c1} for i_data[1] in [3:2], {c0,c1} for i_data[0] in [1:0]
//   o_valid       o_code valid
//   o_last        final (tail) beat of the frame
//   o_busy        not IDLE

// One bit step of the encoder: the code bits for input b and the shifted state.
module conv_encoder_r4_bit #(
  parameter int             K  = 3,
  parameter logic [K-1:0]   G0 = 3'b111,
  parameter logic [K-1:0]   G1 = 3'b101
) (
  input  logic         b_i,
  input  logic [K-2:0] s_i,
  output logic [1:0]   c_o,
  output logic [K-2:0] s_o
);
  logic [K-1:0] r;
  assign r   = {b_i, s_i};
  assign c_o = {^(r & G0), ^(r & G1)};
  assign s_o = {b_i, s_i[K-2:1]};
endmodule

module conv_encoder_r4 #(
  parameter int           K         = 3,
  parameter logic [K-1:0] G0        = 3'b111,
  parameter logic [K-1:0] G1        = 3'b101,
  parameter int           FRAME_LEN = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       i_start,
  input  logic [1:0] i_data,
  input  logic       i_valid,
  output logic       o_ready,
  input  logic       i_ready,
  output logic [3:0] o_code,
  output logic       o_valid,
  output logic       o_last,
  output logic       o_busy
);
  localparam int DATA_BEATS = FRAME_LEN / 2;
  localparam int TAIL_BEATS = (K - 1) / 2;
  localparam int MAX_BEATS  = (DATA_BEATS > TAIL_BEATS) ? DATA_BEATS : TAIL_BEATS;
  localparam int CW         = $clog2(MAX_BEATS + 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BEATS - 1);
  localparam logic [CW-1:0] TAIL_LAST = CW'(TAIL_BEATS - 1);

  typedef enum logic [1:0] {IDLE, ENC, TAIL} state_e;

  state_e        state_q, state_d;
  logic [K-2:0]  s_q, s_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    code_q, code_d;
  logic          valid_q, valid_d;
  logic          last_q, last_d;

  logic          slot_free, load, tail_last;
  logic [1:0]    din, c_hi, c_lo;
  logic [K-2:0]  s_mid, s_end;

  // Tail beats feed zeros through the same two-bit datapath.
  assign din = (state_q == TAIL) ? 2'b00 : i_data;

  // i_data[1] is earlier in time, so it goes through first.
  conv_encoder_r4_bit #(.K(K), .G0(G0), .G1(G1)) u_bit_hi (
    .b_i(din[1]), .s_i(s_q),   .c_o(c_hi), .s_o(s_mid)
  );
  conv_encoder_r4_bit #(.K(K), .G0(G0), .G1(G1)) u_bit_lo (
    .b_i(din[0]), .s_i(s_mid), .c_o(c_lo), .s_o(s_end)
  );

  // Output slot frees up when empty or being drained this cycle.
  assign slot_free = !valid_q || i_ready;
  assign o_ready   = en && (state_q == ENC) && slot_free;

  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    cnt_d     = cnt_q;
    code_d    = code_q;
    valid_d   = valid_q;
    last_d    = last_q;
    load      = 1'b0;
    tail_last = 1'b0;
    if (en) begin
      unique case (state_q)
        IDLE: if (i_start) begin
          s_d     = '0;
          cnt_d   = '0;
          state_d = ENC;
        end
        ENC: if (i_valid && slot_free) begin
          load = 1'b1;
          s_d  = s_end;
          if (cnt_q == DATA_LAST) begin
            cnt_d   = '0;
            state_d = TAIL;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        TAIL: if (slot_free) begin
          load = 1'b1;
          s_d  = s_end;
          if (cnt_q == TAIL_LAST) begin
            tail_last = 1'b1;
            cnt_d     = '0;
            state_d   = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
      // A new load replaces the old beat in the same cycle it is taken.
      if (load) begin
        code_d  = {c_hi, c_lo};
        valid_d = 1'b1;
        last_d  = tail_last;
      end else if (i_ready) begin
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      cnt_q   <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign o_code  = code_q;
  assign o_valid = valid_q;
  assign o_last  = last_q;
  assign o_busy  = (state_q != IDLE);
endmodule

// File: tb/tb_conv_encoder_r4.sv
// Bench for conv_encoder_r4: directed and random frames, checked against a
// convolution model (each code bit is the XOR of generator taps over the
// input bit history, with zero tail bits appended).
module tb_conv_encoder_r4;
  localparam int K  = 3;
  localparam int FL = 16;
  localparam int NB = FL / 2 + (K - 1) / 2;

  logic       clk = 1'b0, rst = 1'b0, en = 1'b0, i_start = 1'b0;
  logic       i_valid = 1'b0, i_ready = 1'b0;
  logic [1:0] i_data = 2'b00;
  logic       o_ready, o_valid, o_last, o_busy;
  logic [3:0] o_code;

  conv_encoder_r4 #(.K(K), .G0(3'b111), .G1(3'b101), .FRAME_LEN(FL)) dut (
    .clk(clk), .rst(rst), .en(en), .i_start(i_start), .i_data(i_data),
    .i_valid(i_valid), .o_ready(o_ready), .i_ready(i_ready), .o_code(o_code),
    .o_valid(o_valid), .o_last(o_last), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {logic [3:0] code; logic last;} beat_t;

  beat_t      exp_q[$];
  logic [1:0] src_q[$];
  logic [1:0] frame_q[$];
  int         take_cyc[$];
  int         n_assert = 0, n_fail = 0, cyc = 0;
  int         p_valid = 100, p_ready = 100, p_en = 100;
  logic [K-1:0] g0 = 3'b111, g1 = 3'b101;
  logic [3:0] snap_code;
  logic       snap_valid, snap_last;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Sample at negedge (what the next posedge will see), then drive after it.
  task automatic tick();
    beat_t b;
    @(negedge clk);
    if (rst && en && o_valid && i_ready) begin
      take_cyc.push_back(cyc);
      if (exp_q.size() == 0) chk("extra_beat", 1, 0);
      else begin
        b = exp_q.pop_front();
        chk("code", o_code, b.code);
        chk("last", o_last, b.last);
      end
    end
    if (rst && i_valid && o_ready && src_q.size() > 0) void'(src_q.pop_front());
    @(posedge clk); #1;
    cyc++;
    en      = ($urandom_range(99) < p_en);
    i_ready = ($urandom_range(99) < p_ready);
    i_valid = (src_q.size() > 0) && ($urandom_range(99) < p_valid);
    i_data  = (src_q.size() > 0) ? src_q[0] : 2'($urandom);
    #1;
  endtask

  // Expected beats: bit n codes as XOR_i G[K-1-i] & x[n-i], x[<0] = 0.
  task automatic load_frame();
    int x[$];
    int nb, n, c0, c1;
    beat_t b;
    foreach (frame_q[i]) begin
      x.push_back(int'(frame_q[i][1]));
      x.push_back(int'(frame_q[i][0]));
      src_q.push_back(frame_q[i]);
    end
    for (int i = 0; i < K - 1; i++) x.push_back(0);
    nb = x.size() / 2;
    for (int j = 0; j < nb; j++) begin
      b.code = '0;
      for (int h = 0; h < 2; h++) begin
        n = 2 * j + h; c0 = 0; c1 = 0;
        for (int i = 0; i < K; i++)
          if (n - i >= 0) begin
            c0 ^= int'(g0[K-1-i]) & x[n-i];
            c1 ^= int'(g1[K-1-i]) & x[n-i];
          end
        if (h == 0) b.code[3:2] = {c0[0], c1[0]};
        else        b.code[1:0] = {c0[0], c1[0]};
      end
      b.last = (j == nb - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic rand_frame();
    frame_q.delete();
    for (int i = 0; i < FL / 2; i++) frame_q.push_back(2'($urandom));
  endtask

  task automatic start_frame();
    int guard = 0;
    while (o_busy && guard < 500) begin tick(); guard++; end
    chk("idle_before_start", o_busy, 0);
    load_frame();
    en = 1'b1; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk("busy_after_start", o_busy, 1);
  endtask

  task automatic finish_frame();
    int guard = 0;
    while ((exp_q.size() > 0 || src_q.size() > 0) && guard < 3000) begin
      tick(); guard++;
    end
    chk("frame_done_in_budget", guard < 3000, 1);
    chk("idle_after_frame", o_busy, 0);
    exp_q.delete(); src_q.delete();
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", o_valid, 0);
    chk("rst_last", o_last, 0);
    chk("rst_code", o_code, 0);
    chk("rst_busy", o_busy, 0);
    rst = 1'b1; en = 1'b1; #1;
    chk("idle_ready", o_ready, 0);
    tick();

    // Directed frame: first beat 10 (codes 1110), ending 11,11 then tail
    frame_q.delete();
    frame_q.push_back(2'b10);
    for (int i = 0; i < FL / 2 - 3; i++) frame_q.push_back(2'($urandom));
    frame_q.push_back(2'b11);
    frame_q.push_back(2'b11);
    start_frame();
    finish_frame();

    // All zeros at full throughput: NB back-to-back beats
    frame_q.delete();
    for (int i = 0; i < FL / 2; i++) frame_q.push_back(2'b00);
    take_cyc.delete();
    start_frame();
    finish_frame();
    chk("zero_beats", take_cyc.size(), NB);
    if (take_cyc.size() == NB) chk("zero_no_gaps", take_cyc[NB-1] - take_cyc[0], NB - 1);

    // Backpressure for 3 cycles mid-frame
    rand_frame();
    start_frame();
    repeat (3) tick();
    p_ready = 0; i_ready = 1'b0; #1;
    snap_code = o_code;
    chk("bp_valid_before", o_valid, 1);
    chk("bp_ready_low", o_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_code_hold", o_code, snap_code);
      chk("bp_valid_hold", o_valid, 1);
      chk("bp_ready_hold", o_ready, 0);
    end
    p_ready = 100;
    finish_frame();

    // i_start pulse in ENC, then en=0 for 2 cycles in TAIL
    rand_frame();
    start_frame();
    repeat (2) tick();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int g = 0; g < 200 && src_q.size() > 0; g++) tick();
    p_en = 0; en = 1'b0; #1;
    snap_code = o_code; snap_valid = o_valid; snap_last = o_last;
    chk("tail_busy", o_busy, 1);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("en0_code", o_code, snap_code);
      chk("en0_valid", o_valid, snap_valid);
      chk("en0_last", o_last, snap_last);
      chk("en0_busy", o_busy, 1);
      chk("en0_ready", o_ready, 0);
    end
    p_en = 100;
    finish_frame();

    // Random frames with random valid/ready/enable
    for (int f = 0; f < 6; f++) begin
      p_valid = $urandom_range(100, 40);
      p_ready = $urandom_range(100, 40);
      p_en    = $urandom_range(100, 70);
      rand_frame();
      start_frame();
      finish_frame();
    end
    p_valid = 100; p_ready = 100; p_en = 100;

    // Reset mid-ENC, then re-encode from state 0
    rand_frame();
    start_frame();
    repeat (3) tick();
    rst = 1'b0; #1;
    chk("mid_rst_valid", o_valid, 0);
    chk("mid_rst_busy", o_busy, 0);
    chk("mid_rst_last", o_last, 0);
    chk("mid_rst_code", o_code, 0);
    chk("mid_rst_ready", o_ready, 0);
    src_q.delete(); exp_q.delete();
    tick();
    rst = 1'b1;
    rand_frame();
    start_frame();
    finish_frame();

    // Nothing further may appear
    repeat (5) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/conv_encoder_r4.md
Name: conv_encoder_r4

Overview:
- Radix-4 convolutional encoder: the transmit-side counterpart of the Viterbi decoder datapath.
- Consumes 2 data bits per cycle and emits 4 coded bits per cycle: two rate-1/2 symbols.
- Zero-terminates each frame with K-1 tail bits, so the decoder traceback starts from state 0.
- Sits between the test data source and the decoder input (channel model optional in between).

Parameters:
- K, 3, constraint length; must be odd so that (K-1)/2 tail beats is an integer.
- G0, 3'b111, generator polynomial for the first code bit of each symbol (MSB applies to the current input bit).
- G1, 3'b101, generator polynomial for the second code bit.
- FRAME_LEN, 16, data bits per frame; must be even and at least 2.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  global enable; 0 freezes all state.
- i_start  input  1  frame start pulse; sampled only in IDLE.
- i_data  input  2  data beat; [1] is the earlier bit in time.
- i_valid  input  1  i_data valid.
- o_ready  output  1  encoder accepts i_data this cycle.
- i_ready  input  1  downstream accepts o_code this cycle.
- o_code  output  4  [3:2] = {G0,G1} bits for i_data[1]; [1:0] = {G0,G1} bits for i_data[0].
- o_valid  output  1  o_code valid.
- o_last  output  1  marks the final (tail) beat of the frame.
- o_busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=0, async) sets:
  - state = IDLE, shift register = 0, beat counter = 0.
  - o_code = 0, o_valid = 0, o_last = 0, o_busy = 0.
- en=0:
  - All registers hold.
  - o_ready = 0.
  - o_valid, o_code and o_last hold their values.
- Shift register s holds the previous K-1 bits; s[K-2] is the most recent.
- Per-bit encoding for input bit b:
  - r = {b, s}.
  - c0 = XOR-reduce(r & G0).
  - c1 = XOR-reduce(r & G1).
  - Then s <= {b, s[K-2:1]}.
- Each beat applies the per-bit step twice, combinationally, in a single cycle: i_data[1] first, then i_data[0].
- Output slot is free when (!o_valid || i_ready).
- o_ready = en && state==ENC && slot free.
- Input accept = i_valid && o_ready.
- Output register:
  - Loads on accept, or on a tail emission in TAIL; o_valid=1 the next cycle (latency 1).
  - Holds while o_valid && !i_ready.
  - If i_ready and nothing new loads, o_valid clears.
- States:
  - IDLE:
    - o_busy=0.
    - en && i_start: clear s and counter, go to ENC.
    - o_valid may still be draining the previous frame's tail beat.
  - ENC:
    - Each accept increments the counter.
    - Accept with counter == FRAME_LEN/2-1: clear counter, go to TAIL.
    - i_valid while o_ready=0 is not consumed; the source holds i_data.
  - TAIL:
    - When en && slot free, emit one beat with input 00; counter increments.
    - The last tail beat (counter == (K-1)/2-1) sets o_last=1, then state goes to IDLE.
    - o_last is cleared when that beat is taken by the downstream or replaced by a new load.
- Frame output = FRAME_LEN/2 data beats + (K-1)/2 tail beats. Defaults give 8+1=9 beats.
- i_start outside IDLE is ignored; there is no abort mid-frame except by reset.
- Reset mid-frame discards all state immediately; no partial tail is emitted.
- Simultaneous i_ready and new load in the same cycle: the old beat is taken and the new beat is loaded with no bubble, so full throughput is 1 beat/cycle.
- The counter width holds max(FRAME_LEN/2, (K-1)/2) without wrap.

Test Plan:
- Reset: assert rst=0 mid-ENC -> next edge shows o_valid=0, o_busy=0, state IDLE; a following i_start re-encodes the frame from s=0.
- Single beat, FRAME_LEN=2, defaults: i_start, then i_data=2'b10 -> o_code=4'b1110; then tail o_code=4'b1100 with o_last=1; o_busy drops after the tail beat.
- All ones, FRAME_LEN=4, i_data=2'b11 twice -> beats 4'b1101, 4'b1010; tail 4'b0111 with o_last=1.
- All zeros, FRAME_LEN=16 -> 9 beats, all 4'b0000; o_last set only on beat 9; no gaps when i_valid and i_ready stay high.
- Backpressure: i_ready=0 for 3 cycles mid-frame -> o_code/o_valid held stable, o_ready=0, no beat lost or duplicated; output sequence matches a golden bit-serial model.
- en=0 for 2 cycles during TAIL, plus i_start pulsed in ENC -> no state change during the en=0 cycles and no frame restart; the frame completes with the correct beat count.
